rr_mux_arbiter_4: RTL

Round-robin arbiter and output register that shares one WIDTH-bit datapath among four requesters through a 4:1 select.

- Each requester presents data with a valid/ready handshake.
- The block picks one winner per transfer and drives the mux select.
- The selected word is registered onto a single valid/ready output channel.
- It sits between four producer blocks and one downstream consumer, and owns the select of the shared 4:1 mux.

---
 rtl/rr_mux_arbiter_4.sv | 103 ++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter feeding a registered 4:1 mux onto one valid/ready channel.
// Priority pointer advances past each winner; idle cycles leave it untouched.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic [1:0]       sel_q, sel_next;
    logic [1:0]       ptr_q, ptr_next;
    logic             load;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [WIDTH-1:0] win_data;

    assign load = (state == EMPTY) || out_ready;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_data = d0;
        unique case (win)
            2'd0: win_data = d0;
            2'd1: win_data = d1;
            2'd2: win_data = d2;
            2'd3: win_data = d3;
        endcase
    end

    // Reset gates grants so nothing is taken while the register is held clear.
    always_comb begin
        req_ready = 4'b0000;
        if (rst_n && load && found)
            req_ready[win] = 1'b1;
    end

    always_comb begin
        state_next = state;
        data_next  = data_q;
        sel_next   = sel_q;
        ptr_next   = ptr_q;
        if (load) begin
            if (found) begin
                state_next = FULL;
                data_next  = win_data;
                sel_next   = win;
                ptr_next   = win + 2'd1;
            end else begin
                state_next = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
            sel_q  <= 2'd0;
            ptr_q  <= 2'd0;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            sel_q  <= sel_next;
            ptr_q  <= ptr_next;
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
